mdl_cmdreg_arb: RTL and testbench
=================================

Name: mdl_cmdreg_arb

Overview:
CPU-side command register and request scheduler for the bubble controller FSM.
- Captures asynchronous CPU writes (command, page number) and validates the command.
- Presents RDREQ/WRREQ to the FSM only in a fixed ROT20 slot, so the FSM's nROT20[9] sampling always sees stable levels.
- Tracks the request life cycle (posted, accepted, done) and exposes a readable status byte.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the CPU strobe synchronizer (minimum 2).
- PAGE_W, 12, width of the page-number register.

Ports:
- i_MCLK  in  1  master clock.
- i_RST  in  1  asynchronous, active-high reset.
- i_CLK2M_PCEN_n  in  1  2 MHz clock enable, active low; all state advances only when this is low.
- i_ROT20_n  in  20  one-hot-low rotation timing.
- i_CPU_CS_n  in  1  chip select, asynchronous.
- i_CPU_WR_n  in  1  write strobe, asynchronous.
- i_CPU_RD_n  in  1  read strobe, asynchronous.
- i_CPU_ADDR  in  2  register select: 0 = CMD, 1 = PAGE_LO, 2 = PAGE_HI, 3 = STATUS.
- i_CPU_DIN  in  8  write data; stable while the strobe is low.
- o_CPU_DOUT  out  8  read data; STATUS for addr 3, otherwise 0x00.
- i_CMDREG_RST_n  in  1  from the FSM; low = request consumed.
- i_CMD_ACCEPTED_n  in  1  from the FSM; low = operation started.
- i_OP_DONE  in  1  operation complete.
- i_SYS_ERR_FLAG  in  1  reflected in STATUS.
- o_CMDREG_RDREQ  out  1  read request to the FSM.
- o_CMDREG_WRREQ  out  1  write request to the FSM.
- o_PAGE_NUM  out  PAGE_W  page number, frozen while busy.
- o_ABORT  out  1  one-enable-cycle pulse on an abort command.

Behaviour:
CPU access detection
- Access strobe = ~CS_n & ~WR_n (write) or ~CS_n & ~RD_n (read).
- Each strobe passes through a SYNC_STAGES synchronizer clocked on MCLK gated by CLK2M_PCEN_n.
- An access event is the synchronized 1->0 edge of the strobe (end of access).
- DIN and ADDR are captured in a holding register while the synchronized strobe is 1, then committed on the event.

Reset values
- State = IDLE.
- RDREQ = 0, WRREQ = 0, ABORT = 0.
- PAGE_NUM = 0.
- Status flags = 0.
- DOUT = 0.

Command byte
- bit0 = RD, bit1 = WR, bit7 = ABORT; all other bits ignored.
- RD and WR both 1 is illegal: set CMD_ERR, no request.
- RD and WR both 0 (with bit7 = 0) is a no-op.

State machine (advances only on enabled cycles)
- IDLE:
  - Valid CMD write latches the request type and goes to PENDING.
  - PAGE_LO writes load PAGE_NUM[7:0].
  - PAGE_HI writes load PAGE_NUM[PAGE_W-1:8].
- PENDING: at ROT20_n[0] == 0, drive RDREQ/WRREQ and go to POSTED. Minimum latency from the CMD write event to the request output is 1 enabled cycle; maximum is 20.
- POSTED: i_CMDREG_RST_n low clears RDREQ/WRREQ.
  - If i_CMD_ACCEPTED_n is low in the same cycle or later, go to ACTIVE.
  - If CMDREG_RST_n fires without acceptance (FSM error restart), return to IDLE.
- ACTIVE: i_OP_DONE high returns to IDLE.

Busy and overrun
- BUSY = state is PENDING, POSTED or ACTIVE.
- While BUSY, CMD and PAGE writes are dropped and set OVERRUN; PAGE_NUM is unchanged.

Abort
- A CMD write with bit7 = 1 in any state:
  - clears both requests,
  - pulses o_ABORT for one enabled cycle,
  - returns to IDLE.
- Abort takes priority over a simultaneous CMDREG_RST_n or OP_DONE.
- RD/WR bits in the same byte are ignored.

Simultaneous events
- CMD write event and OP_DONE in the same cycle: OP_DONE is processed first (go to IDLE); the write counts as a write while busy and sets OVERRUN.

STATUS byte (addr 3)
- bit0 = BUSY, bit1 = request posted, bit2 = CMD_ERR, bit3 = OVERRUN, bit4 = i_SYS_ERR_FLAG, others 0.
- DOUT is combinational from the status register while the read strobe is active.
- The end-of-read event clears CMD_ERR and OVERRUN.
- A flag set in the same cycle as that clear wins (stays set).

Mid-operation reset
- i_RST clears everything asynchronously, regardless of CLK2M_PCEN_n.
- Requests drop immediately.

Decomposition:
- Shared package (mdl_cmdreg_pkg): state encoding constants, register address constants, command bit positions, status bit positions.
- Sub-module: mdl_async_strobe_sync (SYNC_STAGES flip-flops plus falling-edge detect, clock-enabled), instantiated twice (write, read).

Test Plan:
- Write PAGE_LO=0x34, PAGE_HI=0x02, then CMD=0x01 at ROT20 slot 7 -> PAGE_NUM=0x234; RDREQ rises at the next slot 0 only; WRREQ stays 0; STATUS reads 0x03.
- CMD=0x03 -> no request, STATUS=0x04; a second STATUS read -> 0x00.
- With WRREQ posted, pulse CMDREG_RST_n and CMD_ACCEPTED_n, then OP_DONE after 50 cycles -> WRREQ clears on the RST cycle, BUSY stays 1 until OP_DONE, then STATUS=0x00.
- While ACTIVE, write PAGE_LO=0xFF and CMD=0x02 -> PAGE_NUM unchanged, no new request, OVERRUN set.
- While POSTED, write CMD=0x80 in the same cycle as CMDREG_RST_n -> o_ABORT pulses once, requests 0, state IDLE, BUSY=0.
- Assert i_RST while ACTIVE with CLK2M_PCEN_n held high -> all outputs 0 immediately; after release, a CMD=0x01 write is accepted normally.

Source files
------------

// File: rtl/mdl_cmdreg_pkg.sv
// mdl_cmdreg_pkg
// Shared constants for the CPU command register / request scheduler:
// scheduler state encoding, CPU register addresses, command byte bit
// positions, STATUS byte bit positions and a STATUS packing helper.
package mdl_cmdreg_pkg;

  // Scheduler states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_POSTED  = 2'd2;
  localparam logic [1:0] ST_ACTIVE  = 2'd3;

  // CPU register map
  localparam logic [1:0] ADDR_CMD     = 2'd0;
  localparam logic [1:0] ADDR_PAGE_LO = 2'd1;
  localparam logic [1:0] ADDR_PAGE_HI = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // Command byte fields
  localparam int CMD_RD_BIT    = 0;
  localparam int CMD_WR_BIT    = 1;
  localparam int CMD_ABORT_BIT = 7;

  // STATUS byte fields
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_POSTED_BIT  = 1;
  localparam int STAT_CMD_ERR_BIT = 2;
  localparam int STAT_OVERRUN_BIT = 3;
  localparam int STAT_SYS_ERR_BIT = 4;

  function automatic logic [7:0] pack_status(input logic busy,
                                             input logic posted,
                                             input logic cmd_err,
                                             input logic overrun,
                                             input logic sys_err);
    logic [7:0] s;
    s                   = 8'h00;
    s[STAT_BUSY_BIT]    = busy;
    s[STAT_POSTED_BIT]  = posted;
    s[STAT_CMD_ERR_BIT] = cmd_err;
    s[STAT_OVERRUN_BIT] = overrun;
    s[STAT_SYS_ERR_BIT] = sys_err;
    return s;
  endfunction

endpackage

// File: rtl/mdl_async_strobe_sync.sv
// mdl_async_strobe_sync
// Synchronizes an asynchronous CPU strobe into the i_MCLK domain and flags
// the end of the access (synchronized 1->0 edge). All stages advance only on
// clock-enabled cycles.
// Ports:
//   i_MCLK    master clock
//   i_RST     asynchronous active-high reset
//   i_CE      clock enable (active high)
//   i_STROBE  asynchronous strobe, 1 = access in progress
//   o_LEVEL   synchronized strobe level
//   o_FALL    end-of-access event, valid for one enabled cycle
module mdl_async_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_MCLK,
  input  logic i_RST,
  input  logic i_CE,
  input  logic i_STROBE,
  output logic o_LEVEL,
  output logic o_FALL
);

  // [SYNC_STAGES-1:0] is the synchronizer chain; the extra top bit is the
  // previous synchronized level used for edge detection.
  logic [SYNC_STAGES:0] sync_reg;

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      sync_reg <= '0;
    end else if (i_CE) begin
      sync_reg <= {sync_reg[SYNC_STAGES-1:0], i_STROBE};
    end
  end

  assign o_LEVEL = sync_reg[SYNC_STAGES-1];
  assign o_FALL  = sync_reg[SYNC_STAGES] & ~sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/mdl_cmdreg_arb.sv
// mdl_cmdreg_arb
// CPU-side command register and request scheduler for the bubble controller
// FSM. Captures CPU writes (command, page number), validates the command,
// presents RDREQ/WRREQ only in ROT20 slot 0 and tracks the request life
// cycle, exposing it through a STATUS byte.
// Ports:
//   i_MCLK, i_RST                 clock, asynchronous active-high reset
//   i_CLK2M_PCEN_n                clock enable (active low)
//   i_ROT20_n                     one-hot-low rotation timing
//   i_CPU_*  / o_CPU_DOUT         asynchronous CPU bus
//   i_CMDREG_RST_n, i_CMD_ACCEPTED_n, i_OP_DONE, i_SYS_ERR_FLAG  FSM side
//   o_CMDREG_RDREQ/WRREQ          requests to the FSM
//   o_PAGE_NUM                    page number (frozen while busy)
//   o_ABORT                       one-enabled-cycle abort pulse
module mdl_cmdreg_arb
  import mdl_cmdreg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PAGE_W      = 12
) (
  input  logic              i_MCLK,
  input  logic              i_RST,
  input  logic              i_CLK2M_PCEN_n,
  input  logic [19:0]       i_ROT20_n,
  input  logic              i_CPU_CS_n,
  input  logic              i_CPU_WR_n,
  input  logic              i_CPU_RD_n,
  input  logic [1:0]        i_CPU_ADDR,
  input  logic [7:0]        i_CPU_DIN,
  output logic [7:0]        o_CPU_DOUT,
  input  logic              i_CMDREG_RST_n,
  input  logic              i_CMD_ACCEPTED_n,
  input  logic              i_OP_DONE,
  input  logic              i_SYS_ERR_FLAG,
  output logic              o_CMDREG_RDREQ,
  output logic              o_CMDREG_WRREQ,
  output logic [PAGE_W-1:0] o_PAGE_NUM,
  output logic              o_ABORT
);

  logic ce;
  logic wr_strobe, rd_strobe;
  logic wr_level, wr_fall, rd_level, rd_fall;

  assign ce        = ~i_CLK2M_PCEN_n;
  assign wr_strobe = ~i_CPU_CS_n & ~i_CPU_WR_n;
  assign rd_strobe = ~i_CPU_CS_n & ~i_CPU_RD_n;

  mdl_async_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .i_MCLK  (i_MCLK),
    .i_RST   (i_RST),
    .i_CE    (ce),
    .i_STROBE(wr_strobe),
    .o_LEVEL (wr_level),
    .o_FALL  (wr_fall)
  );

  mdl_async_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .i_MCLK  (i_MCLK),
    .i_RST   (i_RST),
    .i_CE    (ce),
    .i_STROBE(rd_strobe),
    .o_LEVEL (rd_level),
    .o_FALL  (rd_fall)
  );

  logic [1:0]        state_reg, state_next;
  logic              req_is_wr_reg, req_is_wr_next;
  logic              rdreq_reg, rdreq_next;
  logic              wrreq_reg, wrreq_next;
  logic              abort_reg, abort_next;
  logic              cmd_err_reg, cmd_err_next;
  logic              overrun_reg, overrun_next;
  logic [PAGE_W-1:0] page_reg, page_next;
  logic [1:0]        wr_addr_hold_reg, rd_addr_hold_reg;
  logic [7:0]        wr_data_hold_reg;

  logic busy, cmd_wr, page_lo_wr, page_hi_wr, status_rd;
  logic cmd_rd_bit, cmd_wr_bit, abort_cmd, rot_slot0;

  assign busy       = (state_reg != ST_IDLE);
  assign cmd_wr     = wr_fall && (wr_addr_hold_reg == ADDR_CMD);
  assign page_lo_wr = wr_fall && (wr_addr_hold_reg == ADDR_PAGE_LO);
  assign page_hi_wr = wr_fall && (wr_addr_hold_reg == ADDR_PAGE_HI);
  assign status_rd  = rd_fall && (rd_addr_hold_reg == ADDR_STATUS);
  assign cmd_rd_bit = wr_data_hold_reg[CMD_RD_BIT];
  assign cmd_wr_bit = wr_data_hold_reg[CMD_WR_BIT];
  assign abort_cmd  = cmd_wr && wr_data_hold_reg[CMD_ABORT_BIT];

  // Post only when slot 0 is the single active slot, so a malformed
  // rotation word can never launch a request.
  assign rot_slot0  = ~i_ROT20_n[0] & (&i_ROT20_n[19:1]);

  always_comb begin
    state_next     = state_reg;
    req_is_wr_next = req_is_wr_reg;
    rdreq_next     = rdreq_reg;
    wrreq_next     = wrreq_reg;
    abort_next     = abort_cmd;
    page_next      = page_reg;

    // Any CMD/PAGE write seen while busy (including the cycle OP_DONE
    // retires the operation) is dropped and flagged. A clear from a STATUS
    // read loses against a set in the same cycle.
    cmd_err_next = (cmd_err_reg & ~status_rd) |
                   (!busy && cmd_wr && !abort_cmd && cmd_rd_bit && cmd_wr_bit);
    overrun_next = (overrun_reg & ~status_rd) |
                   (busy && !abort_cmd && (cmd_wr || page_lo_wr || page_hi_wr));

    if (!busy && page_lo_wr) page_next[7:0] = wr_data_hold_reg;
    if (!busy && page_hi_wr) page_next[PAGE_W-1:8] = wr_data_hold_reg[PAGE_W-9:0];

    if (abort_cmd) begin
      state_next = ST_IDLE;
      rdreq_next = 1'b0;
      wrreq_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_wr && (cmd_rd_bit ^ cmd_wr_bit)) begin
            req_is_wr_next = cmd_wr_bit;
            state_next     = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (rot_slot0) begin
            rdreq_next = ~req_is_wr_reg;
            wrreq_next = req_is_wr_reg;
            state_next = ST_POSTED;
          end
        end
        ST_POSTED: begin
          if (!i_CMDREG_RST_n) begin
            rdreq_next = 1'b0;
            wrreq_next = 1'b0;
          end
          if (!i_CMD_ACCEPTED_n) begin
            state_next = ST_ACTIVE;
          end else if (!i_CMDREG_RST_n) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          // ACTIVE: acceptance may have preceded the consume strobe
          if (!i_CMDREG_RST_n || i_OP_DONE) begin
            rdreq_next = 1'b0;
            wrreq_next = 1'b0;
          end
          if (i_OP_DONE) state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state_reg        <= ST_IDLE;
      req_is_wr_reg    <= 1'b0;
      rdreq_reg        <= 1'b0;
      wrreq_reg        <= 1'b0;
      abort_reg        <= 1'b0;
      cmd_err_reg      <= 1'b0;
      overrun_reg      <= 1'b0;
      page_reg         <= '0;
      wr_addr_hold_reg <= '0;
      wr_data_hold_reg <= '0;
      rd_addr_hold_reg <= '0;
    end else if (ce) begin
      state_reg     <= state_next;
      req_is_wr_reg <= req_is_wr_next;
      rdreq_reg     <= rdreq_next;
      wrreq_reg     <= wrreq_next;
      abort_reg     <= abort_next;
      cmd_err_reg   <= cmd_err_next;
      overrun_reg   <= overrun_next;
      page_reg      <= page_next;
      // Bus contents are sampled while the synchronized strobe is high and
      // used when the falling edge arrives.
      if (wr_level) begin
        wr_addr_hold_reg <= i_CPU_ADDR;
        wr_data_hold_reg <= i_CPU_DIN;
      end
      if (rd_level) begin
        rd_addr_hold_reg <= i_CPU_ADDR;
      end
    end
  end

  assign o_CMDREG_RDREQ = rdreq_reg;
  assign o_CMDREG_WRREQ = wrreq_reg;
  assign o_ABORT        = abort_reg;
  assign o_PAGE_NUM     = page_reg;
  assign o_CPU_DOUT     = (rd_strobe && (i_CPU_ADDR == ADDR_STATUS)) ?
                          pack_status(busy, rdreq_reg | wrreq_reg, cmd_err_reg,
                                      overrun_reg, i_SYS_ERR_FLAG) : 8'h00;

endmodule

// File: tb/tb_mdl_cmdreg_arb.sv
// tb_mdl_cmdreg_arb
// Scoreboard bench: stimulus tasks update a behavioural model and push the
// expected DUT responses (request launch, abort pulse, read data) into a
// queue; an independent monitor pops and compares when the DUT presents them.
module tb_mdl_cmdreg_arb;

  localparam int PAGE_W = 12;
  localparam int K_REQ = 0, K_ABORT = 1, K_READ = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pcen_n = 1'b1;
  logic [19:0]       rot_n = 20'hFFFFE;
  logic              cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1;
  logic [1:0]        addr = 2'd0;
  logic [7:0]        din = 8'h00;
  logic [7:0]        dout;
  logic              cmdreg_rst_n = 1'b1, acc_n = 1'b1, op_done = 1'b0, sys_err = 1'b0;
  logic              rdreq, wrreq, abort;
  logic [PAGE_W-1:0] page;

  always #5 clk = ~clk;

  mdl_cmdreg_arb #(.SYNC_STAGES(2), .PAGE_W(PAGE_W)) dut (
    .i_MCLK          (clk),
    .i_RST           (rst),
    .i_CLK2M_PCEN_n  (pcen_n),
    .i_ROT20_n       (rot_n),
    .i_CPU_CS_n      (cs_n),
    .i_CPU_WR_n      (wr_n),
    .i_CPU_RD_n      (rd_n),
    .i_CPU_ADDR      (addr),
    .i_CPU_DIN       (din),
    .o_CPU_DOUT      (dout),
    .i_CMDREG_RST_n  (cmdreg_rst_n),
    .i_CMD_ACCEPTED_n(acc_n),
    .i_OP_DONE       (op_done),
    .i_SYS_ERR_FLAG  (sys_err),
    .o_CMDREG_RDREQ  (rdreq),
    .o_CMDREG_WRREQ  (wrreq),
    .o_PAGE_NUM      (page),
    .o_ABORT         (abort)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [7:0]  val;
    logic [11:0] pg;
  } exp_t;
  exp_t exp_q[$];

  logic rd_sample = 1'b0;
  bit   hold_pcen = 1'b0;
  int   slot = 0;

  // Reference model: request life cycle in plain terms
  int          m_state = 0;      // 0 idle, 1 request out, 2 operation running
  logic [1:0]  m_req = 2'b00;    // {wr, rd}
  logic [11:0] m_page = 12'h000;
  bit          m_err = 0, m_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Timing generator: enable every other clock, ROT20 advances per enabled edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_pcen) pcen_n = 1'b1;
      else begin
        if (pcen_n == 1'b0) slot = (slot + 1) % 20;
        pcen_n = ~pcen_n;
      end
      rot_n = ~(20'h1 << slot);
    end
  end

  task automatic pop_exp(input int kind, input string name, output bit ok, output exp_t e);
    e = '{kind: 0, val: 8'h00, pg: 12'h000};
    ok = 0;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: DUT output appeared with nothing expected", name);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        checks++; errors++;
        $display("FAIL %s: output kind %0d, expected kind %0d", name, kind, e.kind);
      end else ok = 1;
    end
  endtask

  // Monitor
  initial begin
    logic prev_req = 1'b0, prev_ab = 1'b0;
    logic [19:0] rot_s;
    logic ce_s;
    int ab_en = 0;
    exp_t e;
    bit ok;
    forever begin
      @(posedge clk);
      rot_s = rot_n;
      ce_s  = ~pcen_n;
      if (prev_ab && ce_s) ab_en++;
      @(negedge clk);
      if (!rst) begin
        if ((rdreq | wrreq) && !prev_req) begin
          chk("req_slot {ce,rot0}", {30'd0, ce_s, rot_s[0]}, 32'h2);
          pop_exp(K_REQ, "req", ok, e);
          if (ok) begin
            chk("req_type {wr,rd}", {30'd0, wrreq, rdreq}, {24'd0, e.val});
            chk("req_page", {20'd0, page}, {20'd0, e.pg});
            $display("REQ  wr=%0b rd=%0b page=0x%03h", wrreq, rdreq, page);
          end
        end
        if (abort && !prev_ab) begin
          ab_en = 0;
          pop_exp(K_ABORT, "abort", ok, e);
          if (ok) chk("abort_reqs", {30'd0, wrreq, rdreq}, 32'h0);
          $display("ABRT pulse");
        end
        if (!abort && prev_ab) chk("abort_width", ab_en, 1);
        if (rd_sample) begin
          pop_exp(K_READ, "read", ok, e);
          if (ok) begin
            chk("read_data", {24'd0, dout}, {24'd0, e.val});
            $display("RD   addr=%0d dout=0x%02h exp=0x%02h", addr, dout, e.val);
          end
        end
      end
      prev_req = rdreq | wrreq;
      prev_ab  = abort;
    end
  end

  // Return just after a posedge, when the following posedge is enabled
  task automatic sync_enabled();
    int guard = 0;
    @(posedge clk); #2;
    while (pcen_n) begin
      @(posedge clk); #2;
      guard++;
      if (guard > 100) begin
        $display("FAIL enable_wait: clock enable never asserted");
        $fatal(1);
      end
    end
  endtask

  // CPU write; optionally drives FSM strobes on the enabled edge that
  // processes the end-of-write event (release + synchronizer depth + 1).
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d,
                           input bit p_rst, input bit p_acc, input bit p_done);
    sync_enabled();
    addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
    repeat (8) @(posedge clk);
    sync_enabled();
    cs_n = 1'b1; wr_n = 1'b1;
    if (p_rst || p_acc || p_done) begin
      sync_enabled();
      sync_enabled();
      cmdreg_rst_n = ~p_rst; acc_n = ~p_acc; op_done = p_done;
      @(posedge clk); #2;
      cmdreg_rst_n = 1'b1; acc_n = 1'b1; op_done = 1'b0;
    end
    repeat (12) @(posedge clk);
  endtask

  task automatic cpu_read(input logic [1:0] a, input logic [7:0] expv);
    sync_enabled();
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    repeat (3) @(posedge clk); #2;
    exp_q.push_back('{kind: K_READ, val: expv, pg: 12'h000});
    rd_sample = 1'b1;
    @(posedge clk); #2;
    rd_sample = 1'b0;
    repeat (4) @(posedge clk);
    sync_enabled();
    cs_n = 1'b1; rd_n = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  task automatic m_write(input logic [1:0] a, input logic [7:0] d);
    bit busy;
    busy = (m_state != 0);
    if (a == 2'd0) begin
      if (d[7]) begin
        exp_q.push_back('{kind: K_ABORT, val: 8'h00, pg: 12'h000});
        m_state = 0; m_req = 2'b00;
      end else if (busy) m_ovr = 1;
      else if (d[0] && d[1]) m_err = 1;
      else if (d[0] || d[1]) begin
        m_state = 1;
        m_req = d[1] ? 2'b10 : 2'b01;
        exp_q.push_back('{kind: K_REQ, val: {6'd0, m_req}, pg: m_page});
      end
    end else if (a == 2'd1 || a == 2'd2) begin
      if (busy) m_ovr = 1;
      else if (a == 2'd1) m_page[7:0] = d;
      else m_page[11:8] = d[3:0];
    end
  endtask

  task automatic m_pulse(input bit p_rst, input bit p_acc, input bit p_done);
    if (m_state == 1 && p_rst) begin
      m_req = 2'b00;
      m_state = p_acc ? 2 : 0;
    end else if (m_state == 2 && p_done) m_state = 0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    m_write(a, d);
    cpu_write(a, d, 0, 0, 0);
    repeat (44) @(posedge clk);
  endtask

  task automatic do_write_with(input logic [1:0] a, input logic [7:0] d,
                               input bit p_rst, input bit p_acc, input bit p_done);
    m_write(a, d);
    m_pulse(p_rst, p_acc, p_done);
    cpu_write(a, d, p_rst, p_acc, p_done);
    repeat (44) @(posedge clk);
  endtask

  task automatic do_read(input logic [1:0] a);
    logic [7:0] e;
    e = 8'h00;
    if (a == 2'd3) begin
      e = {3'b000, sys_err, m_ovr, m_err, |m_req, m_state != 0};
      m_err = 0; m_ovr = 0;
    end
    cpu_read(a, e);
  endtask

  task automatic do_pulse(input bit p_rst, input bit p_acc, input bit p_done);
    m_pulse(p_rst, p_acc, p_done);
    sync_enabled();
    cmdreg_rst_n = ~p_rst; acc_n = ~p_acc; op_done = p_done;
    @(posedge clk); #2;
    cmdreg_rst_n = 1'b1; acc_n = 1'b1; op_done = 1'b0;
    repeat (4) @(posedge clk);
    $display("FSM  rst=%0b acc=%0b done=%0b", p_rst, p_acc, p_done);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, ign;
    logic [1:0] a;
    int op, cat;

    repeat (5) @(posedge clk);
    #2;
    chk("reset_rdreq", rdreq, 0);
    chk("reset_wrreq", wrreq, 0);
    chk("reset_abort", abort, 0);
    chk("reset_page", page, 0);
    chk("reset_dout", dout, 0);
    @(negedge clk); rst = 1'b0;

    // Page load, read request at slot 0, full life cycle
    do_write(2'd1, 8'h34);
    do_write(2'd2, 8'h02);
    chk("page_0x234", page, 12'h234);
    do_write(2'd0, 8'h01);
    do_read(2'd3);
    do_pulse(1, 1, 0);
    chk("rdreq_cleared", rdreq, 0);
    do_read(2'd3);
    repeat (50) @(posedge clk);
    do_pulse(0, 0, 1);
    do_read(2'd3);

    // Illegal command, cleared by read
    do_write(2'd0, 8'h03);
    do_read(2'd3);
    do_read(2'd3);

    // Write request, then writes while ACTIVE overrun
    do_write(2'd0, 8'h02);
    do_pulse(1, 1, 0);
    chk("wrreq_cleared", wrreq, 0);
    do_read(2'd3);
    do_write(2'd1, 8'hFF);
    chk("page_frozen", page, 12'h234);
    do_write(2'd0, 8'h02);
    do_read(2'd3);
    repeat (50) @(posedge clk);
    do_pulse(0, 0, 1);
    do_read(2'd3);
    do_read(2'd3);

    // Abort in the same cycle as the consume strobe
    do_write(2'd0, 8'h01);
    do_write_with(2'd0, 8'h80, 1, 0, 0);
    chk("abort_rdreq", rdreq, 0);
    do_read(2'd3);

    // CMD write coincident with OP_DONE: done wins, write overruns
    do_write(2'd0, 8'h01);
    do_pulse(1, 1, 0);
    do_write_with(2'd0, 8'h02, 0, 0, 1);
    do_read(2'd3);
    do_read(2'd3);

    // Asynchronous reset while ACTIVE with the clock enable held off
    do_write(2'd1, 8'h5A);
    do_write(2'd0, 8'h01);
    do_pulse(1, 1, 0);
    hold_pcen = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_rdreq", rdreq, 0);
    chk("arst_wrreq", wrreq, 0);
    chk("arst_abort", abort, 0);
    chk("arst_page", page, 0);
    m_state = 0; m_req = 2'b00; m_page = 12'h000; m_err = 0; m_ovr = 0;
    #10 rst = 1'b0;
    hold_pcen = 1'b0;
    do_write(2'd0, 8'h01);
    do_pulse(1, 1, 0);
    do_pulse(0, 0, 1);
    do_read(2'd3);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1: begin
          a = 2'($urandom_range(1, 2));
          d = 8'($urandom);
          do_write(a, d);
          chk("rand_page", page, m_page);
        end
        2, 3, 4: begin
          cat = $urandom_range(0, 4);
          ign = 8'($urandom) & 8'h7C;
          case (cat)
            0: d = 8'h80 | 8'($urandom);
            1: d = ign | 8'h01;
            2: d = ign | 8'h02;
            3: d = ign | 8'h03;
            default: d = ign;
          endcase
          do_write(2'd0, d);
        end
        5, 6: begin
          a = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd3;
          do_read(a);
        end
        7, 8: begin
          if (m_state == 1) do_pulse(1, $urandom_range(0, 1) == 1, 0);
          else if (m_state == 2) do_pulse(0, 0, 1);
          else do_pulse($urandom_range(0, 1) == 1, 0, $urandom_range(0, 1) == 1);
        end
        default: sys_err = 1'($urandom);
      endcase
    end
    do_read(2'd3);

    repeat (20) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
